// File: rtl/k_nns_drain_if.sv
// k_nns_drain_if
//   Bundles the signals between the k-NN core, the drain block and the
//   result sink.
//   Snapshot side : knn_in (flat K-slot result bus, slot 0 nearest,
//                   x in the upper W bits of a slot), n_seen (points
//                   streamed so far), snap (capture strobe).
//   Stream side   : m_data {x, y}, m_idx (slot index), m_valid, m_ready,
//                   m_last (final entry of a drain).
//   Modports      : master = the drain block (drives the stream),
//                   slave  = the environment (drives snapshot inputs and
//                   m_ready, consumes the stream).
interface k_nns_drain_if #(
    parameter int W  = 32,
    parameter int K  = 8,
    parameter int CW = 16
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    logic [2*W*K-1:0] knn_in;
    logic [CW-1:0]    n_seen;
    logic             snap;
    logic [2*W-1:0]   m_data;
    logic [IW-1:0]    m_idx;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        input  knn_in, n_seen, snap, m_ready,
        output m_data, m_idx, m_valid, m_last
    );

    modport slave (
        output knn_in, n_seen, snap, m_ready,
        input  m_data, m_idx, m_valid, m_last
    );
endinterface

// File: rtl/k_nns_drain.sv
// k_nns_drain
//   Captures a snapshot of the k-NN core's result bus on snap and replays
//   the occupied slots, nearest first, over a registered valid/ready
//   stream. Lets a slow sink read results while the core keeps running.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     bus       : k_nns_drain_if master (knn_in, n_seen, snap in;
//                 m_data, m_idx, m_valid, m_last out; m_ready in)
//     busy      : high from the cycle after an accepted snap through the
//                 done cycle
//     done      : one-cycle pulse when a drain completes
//     overrun   : sticky flag, a snap arrived while busy; cleared by rst
module k_nns_drain #(
    parameter int W  = 32,
    parameter int K  = 8,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst,
    k_nns_drain_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              overrun
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = $clog2(K + 1);
    localparam logic [CW-1:0] K_CW = CW'(K);
    localparam logic [NW-1:0] K_NW = NW'(K);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  slot_q [K];
    logic [2*W-1:0]  slot_d [K];
    logic [NW-1:0]   nvalid_q, nvalid_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2*W-1:0]  m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            overrun_q, overrun_d;

    logic            handshake;
    logic [NW-1:0]   snap_nvalid;
    logic [IW-1:0]   idx_next;
    logic [NW-1:0]   last_idx;

    // Helper terms: occupied-slot count clamped to K using the full
    // counter width (a wide n_seen must never alias to a small count),
    // the following slot index and the index of the final entry.
    always_comb begin
        snap_nvalid = (bus.n_seen >= K_CW) ? K_NW : NW'(bus.n_seen);
        idx_next    = idx_q + IW'(1);
        last_idx    = nvalid_q - NW'(1);
        handshake   = m_valid_q && bus.m_ready;
    end

    // Next-state and output logic. Every stream output is a register so
    // it naturally holds while the sink stalls; the next entry is loaded
    // into the output register on the handshake that retires the current
    // one, which gives one entry per cycle under continuous ready.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        nvalid_d  = nvalid_q;
        idx_d     = idx_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (bus.snap) begin
                    for (int i = 0; i < K; i++) begin
                        slot_d[i] = bus.knn_in[2*W*i +: 2*W];
                    end
                    nvalid_d = snap_nvalid;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    m_data_d = bus.knn_in[2*W-1:0];
                    if (snap_nvalid == '0) begin
                        // Nothing to emit: go straight to the done cycle.
                        state_d   = FIN;
                        done_d    = 1'b1;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        state_d   = DRAIN;
                        m_valid_d = 1'b1;
                        m_last_d  = (snap_nvalid == NW'(1));
                    end
                end
            end

            DRAIN: begin
                if (bus.snap) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    if (m_last_q) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        state_d   = FIN;
                        done_d    = 1'b1;
                    end else begin
                        idx_d    = idx_next;
                        m_data_d = slot_q[idx_next];
                        m_last_d = (NW'(idx_next) == last_idx);
                    end
                end
            end

            FIN: begin
                if (bus.snap) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts
    // any drain in progress without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int i = 0; i < K; i++) begin
                slot_q[i] <= '0;
            end
            nvalid_q  <= '0;
            idx_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            nvalid_q  <= nvalid_d;
            idx_q     <= idx_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.m_data  = m_data_q;
    assign bus.m_idx   = idx_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_last  = m_last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_k_nns_drain.sv
// tb_k_nns_drain
//   Bench for k_nns_drain with W=8, K=4, CW=16. Snapshots are driven from a
//   vector table plus hand-written overrun and mid-drain reset sequences;
//   expected stream entries are queued when a snap is driven and retired
//   as the DUT presents them.
module tb_k_nns_drain;
    localparam int W  = 8;
    localparam int K  = 4;
    localparam int CW = 16;

    localparam logic [63:0] DATA_A = 64'h0404_0303_0202_0101;
    localparam logic [63:0] DATA_B = 64'h0a0a_0b0b_0c0c_0d0d;
    localparam logic [63:0] DATA_C = 64'h1111_2222_3333_0000;

    typedef struct {
        logic [63:0] knn;
        logic [15:0] n;
        int          mode;
        int          exp_hs;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  idx;
        logic        last;
    } ent_t;

    logic clk;
    logic rst;
    logic busy;
    logic done;
    logic overrun;

    int   compared    = 0;
    int   mismatched  = 0;
    int   cyc         = 0;
    int   hs_count    = 0;
    int   last_hs_cyc = 0;
    bit   prev_stall  = 0;
    bit   exp_overrun = 0;
    ent_t sb[$];
    vec_t vecs[10];

    k_nns_drain_if #(.W(W), .K(K), .CW(CW)) bus ();

    k_nns_drain #(.W(W), .K(K), .CW(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time latency and done placement.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Safety net in case something hangs outside the bounded loops.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got unexpected event, required none", name);
    endtask

    // Sink ready pattern: mode 0 always ready; mode 1 gives 0,0,1,0,1,...
    // counted from the first cycle after the snap.
    function automatic logic readyFor(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (k < 2) return 1'b0;
        return ((k - 2) % 2) == 0;
    endfunction

    // Model: the first min(n, K) slots, nearest first, last on the final one.
    task automatic pushExpected(input logic [63:0] knn, input logic [15:0] n);
        int   nv;
        ent_t e;
        nv = (n > 16'd4) ? 4 : int'(n);
        for (int i = 0; i < nv; i++) begin
            e.data = knn[16*i +: 16];
            e.idx  = 2'(i);
            e.last = (i == nv - 1);
            sb.push_back(e);
        end
    endtask

    // Called at each negedge: any valid entry must be the scoreboard head,
    // a stalled entry must still be valid next cycle, a handshake retires it.
    task automatic sampleCycle();
        ent_t e;
        if (prev_stall) begin
            checkOutput("hold_valid", bus.m_valid, 1'b1);
        end
        if (bus.m_valid) begin
            if (sb.size() == 0) begin
                failNow("unexpected_entry");
            end else begin
                e = sb[0];
                checkOutput("m_data", bus.m_data, e.data);
                checkOutput("m_idx", bus.m_idx, e.idx);
                checkOutput("m_last", bus.m_last, e.last);
                if (bus.m_ready) begin
                    void'(sb.pop_front());
                end
            end
            if (bus.m_ready) begin
                hs_count++;
                last_hs_cyc = cyc;
            end
        end
        prev_stall = bus.m_valid && !bus.m_ready;
    endtask

    // One full drain: snap, then run until done, checking latency, beat
    // count, done placement and busy. The cycle after done is the next
    // call's snap cycle, so consecutive calls exercise snap-after-FIN.
    task automatic applyStimulus(input vec_t v);
        int snap_cyc;
        int done_cyc;
        bit got_done;
        @(posedge clk); #1;
        bus.knn_in  = v.knn;
        bus.n_seen  = v.n;
        bus.snap    = 1'b1;
        bus.m_ready = (v.mode == 0);
        pushExpected(v.knn, v.n);
        @(negedge clk);
        snap_cyc = cyc;
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_done", done, 1'b0);
        checkOutput("idle_valid", bus.m_valid, 1'b0);
        hs_count = 0;
        got_done = 0;
        done_cyc = 0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            @(posedge clk); #1;
            bus.snap    = 1'b0;
            bus.knn_in  = ~v.knn;
            bus.n_seen  = 16'd1;
            bus.m_ready = readyFor(v.mode, k);
            @(negedge clk);
            sampleCycle();
            if (k == 0) begin
                checkOutput("first_valid", bus.m_valid, v.exp_hs > 0);
                checkOutput("busy_after_snap", busy, 1'b1);
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        if (!got_done) begin
            failNow("done_timeout");
        end else begin
            checkOutput("beats", hs_count, v.exp_hs);
            checkOutput("sb_empty", sb.size(), 0);
            checkOutput("done_timing", done_cyc,
                        (v.exp_hs > 0) ? last_hs_cyc + 1 : snap_cyc + 1);
            if (v.mode == 0 && v.exp_hs > 0) begin
                checkOutput("burst_rate", last_hs_cyc, snap_cyc + v.exp_hs);
            end
            checkOutput("busy_in_fin", busy, 1'b1);
            checkOutput("valid_in_fin", bus.m_valid, 1'b0);
            checkOutput("overrun", overrun, exp_overrun);
        end
        sb.delete();
        prev_stall = 0;
    endtask

    initial begin
        bit got_done;

        vecs[0] = '{DATA_A, 16'd10,    0, 4};
        vecs[1] = '{DATA_A, 16'd2,     0, 2};
        vecs[2] = '{DATA_A, 16'd0,     0, 0};
        vecs[3] = '{DATA_A, 16'd10,    1, 4};
        vecs[4] = '{DATA_A, 16'd4,     0, 4};
        vecs[5] = '{DATA_A, 16'd5,     0, 4};
        vecs[6] = '{DATA_A, 16'd1,     0, 1};
        vecs[7] = '{DATA_C, 16'hFFFF,  0, 4};
        vecs[8] = '{DATA_C, 16'd3,     1, 3};
        vecs[9] = '{DATA_A, 16'h0100,  0, 4};

        rst         = 1'b1;
        bus.knn_in  = '0;
        bus.n_seen  = '0;
        bus.snap    = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_valid", bus.m_valid, 1'b0);
        checkOutput("rst_last", bus.m_last, 1'b0);
        checkOutput("rst_data", bus.m_data, 16'h0000);
        checkOutput("rst_idx", bus.m_idx, 2'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Snap during DRAIN: flagged, ignored, first snapshot drains intact.
        hs_count = 0;
        @(posedge clk); #1;
        bus.knn_in  = DATA_A;
        bus.n_seen  = 16'd10;
        bus.snap    = 1'b1;
        bus.m_ready = 1'b0;
        pushExpected(DATA_A, 16'd10);
        @(negedge clk);
        sampleCycle();
        checkOutput("ovr_pre", overrun, 1'b0);
        @(posedge clk); #1;
        bus.snap   = 1'b0;
        bus.knn_in = DATA_B;
        bus.n_seen = 16'd3;
        @(negedge clk);
        sampleCycle();
        @(posedge clk); #1;
        bus.snap    = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        sampleCycle();
        @(posedge clk); #1;
        bus.snap = 1'b0;
        @(negedge clk);
        sampleCycle();
        checkOutput("ovr_set", overrun, 1'b1);
        got_done = 0;
        for (int k = 0; k < 50 && !got_done; k++) begin
            if (done) begin
                got_done = 1;
            end else begin
                @(posedge clk); #1;
                @(negedge clk);
                sampleCycle();
            end
        end
        if (!got_done) failNow("ovr_done_timeout");
        checkOutput("ovr_beats", hs_count, 4);
        checkOutput("ovr_sb_empty", sb.size(), 0);
        checkOutput("ovr_sticky", overrun, 1'b1);
        sb.delete();
        prev_stall  = 0;
        exp_overrun = 1;
        applyStimulus('{DATA_B, 16'd3, 0, 3});

        // Reset after two handshakes: immediate abort, no done pulse.
        hs_count = 0;
        @(posedge clk); #1;
        bus.knn_in  = DATA_A;
        bus.n_seen  = 16'd10;
        bus.snap    = 1'b1;
        bus.m_ready = 1'b1;
        pushExpected(DATA_A, 16'd10);
        @(negedge clk);
        sampleCycle();
        repeat (2) begin
            @(posedge clk); #1;
            bus.snap = 1'b0;
            @(negedge clk);
            sampleCycle();
        end
        checkOutput("rstmid_beats", hs_count, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("rstmid_valid", bus.m_valid, 1'b0);
        checkOutput("rstmid_busy", busy, 1'b0);
        checkOutput("rstmid_done", done, 1'b0);
        checkOutput("rstmid_idx", bus.m_idx, 2'd0);
        checkOutput("rstmid_overrun", overrun, 1'b0);
        sb.delete();
        prev_stall = 0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstmid_no_done", done, 1'b0);
        end
        @(posedge clk); #1;
        rst         = 1'b0;
        exp_overrun = 0;
        applyStimulus('{DATA_A, 16'd10, 0, 4});

        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/k_nns_drain.md
Name: k_nns_drain

Overview:
- Downstream consumer of the sequential k-NN search core.
- On a snapshot strobe, captures the core's flat K-entry nearest-neighbour bus and the count of points streamed so far. It then emits the occupied entries one at a time, nearest first, over a valid/ready stream with a last marker.
- Decouples the core, which updates every cycle, from slower result sinks. Detects and flags snapshots that arrive while a drain is still in progress.

Parameters:
W, 32, coordinate width; each entry is {x[W-1:0], y[W-1:0]}, 2*W bits
K, 8, number of neighbour slots on the core output bus
CW, 16, width of the streamed-point counter input

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
knn_in  in  2*W*K  core result bus; slot i at bits [2*W*(i+1)-1 : 2*W*i]; slot 0 = nearest; x in upper W bits of the slot
n_seen  in  CW  number of database points the core has consumed since its last reset
snap  in  1  single-cycle strobe: capture knn_in and n_seen, start drain
m_data  out  2*W  current entry {x, y}
m_idx  out  log2(K) (min 1)  slot index of current entry
m_valid  out  1  m_data/m_idx/m_last valid
m_ready  in  1  sink accepts entry when m_valid && m_ready
m_last  out  1  current entry is the final one of this drain
busy  out  1  high from accepted snap until done pulse (inclusive of DRAIN state)
done  out  1  one-cycle pulse when a drain completes
overrun  out  1  sticky: a snap arrived while busy; cleared only by rst

Behaviour:
- Reset (async, rst=1): state IDLE. m_valid=0, m_last=0, m_data=0, m_idx=0, busy=0, done=0, overrun=0. Snapshot registers are cleared to 0. Reset mid-drain aborts immediately; no done pulse is issued.
- States: IDLE, DRAIN, FIN.
- IDLE, snap=1:
  - Register knn_in into K snapshot slots.
  - Register nvalid = min(n_seen, K), computed with a CW-bit compare against K, no truncation.
  - Set index=0 and busy=1.
  - If nvalid=0, go to FIN. Otherwise go to DRAIN with m_valid=1 in the next cycle.
- Latency: snap in cycle t gives m_valid=1 with entry 0 in cycle t+1.
- DRAIN:
  - m_data = slot[index], m_idx = index, m_last = (index == nvalid-1).
  - All outputs are registered; they stay stable while m_valid && !m_ready (AXI-style hold rule).
  - On a handshake with m_last=0: index increments and the next entry appears the following cycle. Back-to-back handshakes give 1 entry/cycle.
  - On a handshake with m_last=1: m_valid drops next cycle and the state goes to FIN.
- FIN: lasts one cycle. done=1, busy still 1. Next state is IDLE with busy=0.
- snap while busy (DRAIN or FIN): ignored; the snapshot is not disturbed; overrun<=1.
- snap in IDLE in the cycle right after the FIN cycle is accepted normally.
- Unoccupied slots (index >= n_seen) are never emitted. Slot contents are not inspected; a genuine point at (0,0) is emitted.
- knn_in/n_seen changes after the snap cycle have no effect on the current drain.
- m_ready is ignored when m_valid=0.

Test Plan:
1. W=8, K=4. Reset, then snap with knn_in={16'h0404,16'h0303,16'h0202,16'h0101} (slot3..slot0), n_seen=10, m_ready=1 -> m_data 0101,0202,0303,0404 on consecutive cycles starting at t+1; m_idx 0..3; m_last only on 0404; done one cycle after the 0404 handshake; busy falls the cycle after done.
2. Same snap with n_seen=2 -> only 0101 and 0202 emitted; m_last on 0202; done follows.
3. snap with n_seen=0 -> m_valid never rises; done=1 at t+1; busy high for exactly cycles t+1 and the done cycle.
4. Backpressure: toggle m_ready 0,0,1,0,1,... during case 1 -> each entry is held stable while m_ready=0; order and values are unchanged; exactly 4 handshakes.
5. Second snap during DRAIN, with different knn_in -> overrun=1 and stays 1; drained data equals the first snapshot; a later snap in IDLE drains the new data; overrun is still 1 until rst.
6. Assert rst after two handshakes in case 1 -> m_valid/busy/done go 0 immediately; no done pulse; a fresh snap after release drains from entry 0.
